// File: rtl/cpu_runctl.sv
// Run/halt/step/breakpoint sequencer that gates the Hack CPU clock-enable on a half-rate strobe.
// Build with AUTORUN_EN defined to leave the power-on reset straight into RUN instead of HALT.
module cpu_runctl #(
  parameter int PW      = 15,
  parameter int RST_CYC = 4,
  parameter int CW      = 32
) (
  input  logic          clk50m,
  input  logic          rst,
  input  logic          run_req,
  input  logic          halt_req,
  input  logic          step_req,
  input  logic          bp_en,
  input  logic [PW-1:0] bp_addr,
  input  logic [PW-1:0] pc,
  output logic          en25m,
  output logic          cpu_en,
  output logic          cpu_rst_n,
  output logic          halted,
  output logic          bp_hit,
  output logic [CW-1:0] instr_cnt
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_HALT, S_STEP} state_t;

  localparam logic [7:0] LAST_STRB = 8'(RST_CYC - 1);

  state_t        state_q;
  logic          en25m_q;
  logic          run_p_q, halt_p_q, step_p_q;
  logic [7:0]    strb_q;
  logic          rst_n_q, halted_q, bp_hit_q, bp_skip_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_e, halt_e, step_e, bp_match, cpu_en_w;

  // A request seen in the strobe cycle itself still counts for that strobe.
  assign run_e  = run_p_q  | run_req;
  assign halt_e = halt_p_q | halt_req;
  assign step_e = step_p_q | step_req;

  assign bp_match = bp_en && (pc == bp_addr) && !bp_skip_q;
  assign cpu_en_w = en25m_q && (((state_q == S_RUN) && !bp_match) || (state_q == S_STEP));
  assign cnt_d    = cnt_q + CW'(1);

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      en25m_q   <= 1'b0;
      run_p_q   <= 1'b0;
      halt_p_q  <= 1'b0;
      step_p_q  <= 1'b0;
      strb_q    <= 8'd0;
      rst_n_q   <= 1'b0;
      halted_q  <= 1'b0;
      bp_hit_q  <= 1'b0;
      bp_skip_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      en25m_q <= ~en25m_q;
      if (cpu_en_w) cnt_q <= cnt_d;
      if (!en25m_q) begin
        run_p_q  <= run_e;
        halt_p_q <= halt_e;
        step_p_q <= step_e;
      end else begin
        // Edge ending a strobe: every pending request is consumed, acted on or not.
        run_p_q  <= 1'b0;
        halt_p_q <= 1'b0;
        step_p_q <= 1'b0;
        case (state_q)
          S_INIT: begin
            strb_q <= strb_q + 8'd1;
            if (strb_q == LAST_STRB) begin
              rst_n_q <= 1'b1;
`ifdef AUTORUN_EN
              state_q <= S_RUN;
`else
              state_q  <= S_HALT;
              halted_q <= 1'b1;
`endif
            end
          end
          S_HALT: begin
            if (halt_e) begin
              state_q <= S_HALT;
            end else if (step_e) begin
              state_q  <= S_STEP;
              halted_q <= 1'b0;
            end else if (run_e) begin
              state_q   <= S_RUN;
              halted_q  <= 1'b0;
              bp_hit_q  <= 1'b0;
              bp_skip_q <= 1'b1;
            end
          end
          S_RUN: begin
            bp_skip_q <= 1'b0;
            if (bp_match) begin
              bp_hit_q <= 1'b1;
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else if (halt_e) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
          end
          default: begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign en25m     = en25m_q;
  assign cpu_en    = cpu_en_w;
  assign cpu_rst_n = rst_n_q;
  assign halted    = halted_q;
  assign bp_hit    = bp_hit_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_runctl.sv
// Scoreboard bench for cpu_runctl: per-strobe reference model feeding an expected queue.
module tb_cpu_runctl;

  localparam int PW = 15;
  localparam int RST_CYC = 4;
  localparam int CW = 32;
  localparam int EW = CW + 4;

  localparam int M_INIT = 0, M_HALT = 1, M_RUN = 2, M_STEP = 3;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          run_req = 0, halt_req = 0, step_req = 0, bp_en = 0;
  logic [PW-1:0] bp_addr = '0, pc = '0;
  logic          en25m, cpu_en, cpu_rst_n, halted, bp_hit;
  logic [CW-1:0] instr_cnt;

  cpu_runctl #(.PW(PW), .RST_CYC(RST_CYC), .CW(CW)) u_dut (
    .clk50m(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .en25m(en25m), .cpu_en(cpu_en),
    .cpu_rst_n(cpu_rst_n), .halted(halted), .bp_hit(bp_hit), .instr_cnt(instr_cnt)
  );

  logic       w_rst = 1'b1, w_run = 1'b0;
  logic [3:0] w_pc = '0, w_bpa = '0;
  logic       w_en25m, w_cpu_en, w_rst_n, w_halted, w_bp_hit;
  logic [3:0] w_cnt;

  cpu_runctl #(.PW(4), .RST_CYC(1), .CW(4)) u_wrap (
    .clk50m(clk), .rst(w_rst), .run_req(w_run), .halt_req(1'b0), .step_req(1'b0),
    .bp_en(1'b0), .bp_addr(w_bpa), .pc(w_pc), .en25m(w_en25m), .cpu_en(w_cpu_en),
    .cpu_rst_n(w_rst_n), .halted(w_halted), .bp_hit(w_bp_hit), .instr_cnt(w_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit mon_on = 0;
  logic [EW-1:0] exp_q[$];

  // reference model state
  int            m_mode, m_strb;
  bit            m_bphit, m_skip;
  logic [CW-1:0] m_cnt;
  logic [PW-1:0] m_pc;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_INIT; m_strb = 0; m_bphit = 0; m_skip = 0; m_cnt = '0; m_pc = '0;
  endtask

  // One strobe: report what the outputs must show during it, then apply the spec's rules.
  task automatic model_strobe(input bit r, input bit h, input bit s);
    bit match, en;
    match = bp_en && (m_pc == bp_addr) && !m_skip;
    en = (m_mode == M_STEP) || (m_mode == M_RUN && !match);
    exp_q.push_back({en, (m_mode == M_HALT), m_bphit, (m_mode != M_INIT), m_cnt});
    if (en) begin m_cnt = m_cnt + 1; m_pc = m_pc + 1; end
    case (m_mode)
      M_INIT: begin
        m_strb++;
`ifdef AUTORUN_EN
        if (m_strb == RST_CYC) m_mode = M_RUN;
`else
        if (m_strb == RST_CYC) m_mode = M_HALT;
`endif
      end
      M_HALT: if (!h) begin
        if (s) m_mode = M_STEP;
        else if (r) begin m_mode = M_RUN; m_skip = 1; m_bphit = 0; end
      end
      M_RUN: begin
        m_skip = 0;
        if (match) begin m_bphit = 1; m_mode = M_HALT; end
        else if (h) m_mode = M_HALT;
      end
      default: m_mode = M_HALT;
    endcase
  endtask

  // driver: requests either in the low cycle (pended) or in the strobe cycle itself
  task automatic do_strobe(input bit r, input bit h, input bit s, input bit early,
                           input bit be, input logic [PW-1:0] ba);
    int g = 0;
    @(negedge clk);
    while (en25m !== 1'b0 && g < 4) begin @(negedge clk); g++; end
    if (g >= 4) chk("strobe_align_timeout", 64'(g), 64'(0));
    bp_en = be; bp_addr = ba; pc = m_pc;
    {run_req, halt_req, step_req} = early ? {r, h, s} : 3'b000;
    @(negedge clk);
    {run_req, halt_req, step_req} = early ? 3'b000 : {r, h, s};
    model_strobe(r, h, s);
  endtask

  task automatic idle(input int n, input bit be, input logic [PW-1:0] ba);
    for (int i = 0; i < n; i++) do_strobe(0, 0, 0, 0, be, ba);
  endtask

  // monitor: compares every strobe against the scoreboard, and cpu_en=0 off-strobe
  always @(negedge clk) begin
    logic [EW-1:0] e;
    #2;
    if (mon_on && !rst) begin
      if (en25m) begin
        if (exp_q.size() == 0) chk("strobe_without_expectation", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("strobe_outputs", 64'({cpu_en, halted, bp_hit, cpu_rst_n, instr_cnt}), 64'(e));
        end
      end else begin
        chk("cpu_en_off_strobe", 64'(cpu_en), 64'(0));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_en25m"}, 64'(en25m), 64'(0));
    chk({tag, "_cpu_en"}, 64'(cpu_en), 64'(0));
    chk({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(0));
    chk({tag, "_halted"}, 64'(halted), 64'(0));
    chk({tag, "_bp_hit"}, 64'(bp_hit), 64'(0));
    chk({tag, "_instr_cnt"}, 64'(instr_cnt), 64'(0));
  endtask

  initial begin
    bit r, h, s, be;
    int pulses;
    logic [PW-1:0] ba;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;
    mon_on = 1;

    // power-on sequence, then breakpoint at 5 and resume over it
    idle(6, 0, '0);
    do_strobe(1, 0, 0, 1, 1, PW'(5));
    idle(10, 1, PW'(5));
    do_strobe(1, 0, 0, 0, 1, PW'(5));
    idle(6, 1, PW'(5));
    // simultaneous halt/step/run while running
    do_strobe(1, 1, 1, 0, 0, '0);
    idle(3, 0, '0);
    for (int k = 0; k < 3; k++) begin
      do_strobe(0, 0, 1, k[0], 0, '0);
      idle(3, 0, '0);
    end
    // free run then halt
    do_strobe(1, 0, 0, 0, 0, '0);
    idle(10, 0, '0);
    do_strobe(0, 1, 0, 1, 0, '0);
    idle(2, 0, '0);

    for (int k = 0; k < 250; k++) begin
      r = ($urandom_range(0, 5) == 0);
      h = ($urandom_range(0, 11) == 0);
      s = ($urandom_range(0, 7) == 0);
      be = ($urandom_range(0, 1) == 1);
      ba = m_pc + PW'($urandom_range(0, 6));
      do_strobe(r, h, s, $urandom_range(0, 1) == 1, be, ba);
    end

    // asynchronous reset while running
    do_strobe(1, 0, 0, 0, 0, '0);
    idle(20, 0, '0);
    @(negedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("midrun_reset");
    mon_on = 0;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    mon_on = 1;
    idle(5, 0, '0);
    do_strobe(0, 0, 1, 0, 0, '0);
    do_strobe(1, 0, 0, 1, 0, '0);
    idle(8, 0, '0);
    @(negedge clk);
    mon_on = 0;
    chk("queue_drained_end", 64'(exp_q.size()), 64'(0));

    // CW=4 instance: counter must wrap 15 -> 0
    @(posedge clk); #1 w_rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      w_run = (c >= 4 && c < 8);
      #2;
      chk("wrap_cnt", 64'(w_cnt), 64'(pulses % 16));
      if (w_cpu_en === 1'b1) pulses++;
    end
    chk("wrap_reached", 64'(pulses > 16), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: time %0t reached limit", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_runctl.md
Name: cpu_runctl

Overview:
Run/halt/step sequencer for the Hack CPU core. Derives the half-rate execute strobe from clk50m and holds the CPU in reset for a fixed number of strobes after system reset. Gates the CPU clock-enable per instruction to provide run, halt, single-step and one hardware PC breakpoint. Sits between the top-level clock/reset and the cpu instance; driven by a debug/host interface.

Parameters:
PW, 15, program counter width (matches cpu pc port)
RST_CYC, 4, number of en25m strobes cpu_rst_n is held low after reset (1..255)
CW, 32, instruction counter width

Ports:
clk50m  input  1  system clock
rst  input  1  asynchronous, active-high reset
run_req  input  1  request free-running execution (1-cycle pulse or level)
halt_req  input  1  request halt
step_req  input  1  request execution of exactly one instruction
bp_en  input  1  breakpoint enable
bp_addr  input  PW  breakpoint address
pc  input  PW  current CPU program counter (address of next instruction)
en25m  output  1  free-running strobe, high every second clk50m cycle
cpu_en  output  1  CPU clock-enable; one instruction retires per high cycle
cpu_rst_n  output  1  active-low reset to cpu
halted  output  1  state == HALT
bp_hit  output  1  sticky breakpoint flag
instr_cnt  output  CW  retired-instruction counter

Behaviour:
- Reset (asynchronous, immediate, also mid-operation): en25m=0, cpu_en=0, cpu_rst_n=0, halted=0, bp_hit=0, instr_cnt=0, state=INIT, all pending flags cleared, strobe counter=0.
- en25m: toggle register, 0 in reset, toggles every clk50m edge; first high cycle follows the first edge after rst deasserts.
- Requests: run/halt/step captured into pending flags every clk50m cycle; a request high during an en25m cycle counts in that cycle's evaluation (pending OR input).
- FSM (INIT, RUN, HALT, STEP) updates only at the edge ending an en25m=1 cycle; all pending flags are cleared at every such edge, whether acted on or ignored.
- Priority when several are pending: halt > step > run.
- INIT: cpu_rst_n=0, cpu_en=0. Counts en25m strobes; after the RST_CYC-th strobe, goes to HALT and cpu_rst_n=1. Requests during INIT are discarded.
- HALT: cpu_en=0. step -> STEP. run -> RUN and clears bp_hit. halt is ignored.
- STEP: cpu_en=en25m, breakpoint ignored. After exactly one cpu_en pulse -> HALT. A halt pending in this cycle still lets the step complete.
- RUN:
  - cpu_en = en25m AND NOT bp_match, where bp_match = bp_en AND pc==bp_addr AND NOT bp_skip.
  - On bp_match: no instruction retires, bp_hit=1 (sticky), next state HALT.
  - halt -> HALT after the current instruction retires. step/run are ignored.
- bp_skip: set on the transition HALT->RUN and cleared after the first en25m cycle in RUN, so resuming at the breakpoint address does not re-trigger immediately.
- cpu_en is combinational from state, en25m and bp_match; it is never high while cpu_rst_n=0.
- instr_cnt: +1 on every clk50m cycle with cpu_en=1; wraps from 2^CW-1 to 0.

Optional Feature:
AUTORUN_EN. Defined: INIT exits to RUN (bp_skip not set) instead of HALT, so the CPU runs from pc=0 with no host action. Not defined: INIT exits to HALT and a run_req or step_req is required.

Test Plan:
- Deassert rst, RST_CYC=4, no requests -> cpu_rst_n rises after the 8th clk50m edge; halted=1; cpu_en stays 0; instr_cnt=0.
- From HALT, pulse run_req, let 10 strobes pass, pulse halt_req -> exactly 10 or 11 cpu_en pulses, matching the instr_cnt value; halted=1; no cpu_en while halted.
- From HALT, pulse step_req three times, spaced 6 cycles apart -> exactly 3 cpu_en pulses; instr_cnt=3; halted=1 after each step.
- bp_en=1, bp_addr=0x0005, CPU counting pc 0,1,2... in RUN -> cpu_en low in the strobe with pc=5; bp_hit=1; halted=1; instr_cnt=5. Then run_req -> the instruction at pc=5 executes, bp_hit=0, run continues.
- halt_req, step_req and run_req in the same cycle while in RUN -> HALT; no step performed; later strobes show no pending effect.
- Assert rst while in RUN at instr_cnt=0x10 -> all outputs go to reset values in the same cycle, before the next edge. CW=4 counting run: wrap 15 -> 0.
